trng_sched: RTL and testbench

TRNG_SCHED -- requirements
Module: trng_sched

---
 rtl/trng_pkg.sv | 13 +
 rtl/trng_rct.sv | 37 +++
 rtl/trng_sched.sv | 106 ++++++++++
 tb/tb_trng_sched.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and widths for the TRNG sample scheduler.
package trng_pkg;
   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_FAULT  = 2'd2
   } trng_state_t;

   localparam int DATA_W     = 8;
   localparam int NUM_REQ    = 2;
   localparam int WARM_CNT_W = 16;
   localparam int REP_CNT_W  = 4;
endpackage

// File: rtl/trng_rct.sv
// Repetition count health test: flags the capture at which a run of identical
// samples reaches LIMIT.
module trng_rct
   import trng_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic [DATA_W-1:0] i_sample,
   input  logic              i_capture,
   input  logic              i_restart,
   output logic              o_fail
);

   logic [DATA_W-1:0]    r_prev;
   logic [REP_CNT_W-1:0] r_rep;
   logic [REP_CNT_W-1:0] w_rep_nxt;

   // r_rep == 0 marks "no capture yet", so the first capture always starts a new run
   assign w_rep_nxt = (r_rep != '0 && i_sample == r_prev) ? r_rep + REP_CNT_W'(1)
                                                          : REP_CNT_W'(1);
   assign o_fail    = i_capture && (w_rep_nxt == REP_CNT_W'(LIMIT));

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_rep  <= '0;
         r_prev <= '0;
      end else if (i_restart) begin
         r_rep  <= '0;
      end else if (i_capture) begin
         r_rep  <= w_rep_nxt;
         r_prev <= i_sample;
      end
   end

endmodule

// File: rtl/trng_sched.sv
// TRNG scheduler: warms up the entropy source, health-tests each capture and
// hands captured bytes to two requesters round-robin, each byte at most once.
module trng_sched
   import trng_pkg::*;
#(
   parameter int WARMUP_CYCLES = 64,
   parameter int RCT_LIMIT     = 4
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic [DATA_W-1:0]   src_data,
   output logic                src_en,
   input  logic [NUM_REQ-1:0]  req,
   output logic [NUM_REQ-1:0]  gnt,
   output logic [DATA_W-1:0]   data_out,
   output logic                valid_out,
   output logic                fault,
   input  logic                clr_fault
);

   trng_state_t          r_state, w_state_nxt;
   logic [WARM_CNT_W-1:0] r_warm_cnt;
   logic [DATA_W-1:0]    r_smp;
   logic                 r_smp_valid;
   logic                 r_last;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [DATA_W-1:0]    r_data;
   logic                 r_valid;
   logic                 r_fault;
   logic                 r_src_en;

   logic                 w_run;
   logic                 w_rct_fail;
   logic                 w_grant_en;
   logic                 w_pick;
   logic [NUM_REQ-1:0]   w_gnt;

   assign w_run = (r_state == ST_RUN);

   trng_rct #(.LIMIT(RCT_LIMIT)) u_rct (
      .clk       (clk),
      .n_reset   (n_reset),
      .i_sample  (src_data),
      .i_capture (w_run),
      .i_restart (!w_run),
      .o_fail    (w_rct_fail)
   );

   always_ff @(posedge clk) begin
      if (!n_reset) r_state <= ST_WARMUP;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_WARMUP: if (r_warm_cnt == WARM_CNT_W'(WARMUP_CYCLES - 1)) w_state_nxt = ST_RUN;
         ST_RUN:    if (w_rct_fail) w_state_nxt = ST_FAULT;
         ST_FAULT:  if (clr_fault)  w_state_nxt = ST_WARMUP;
         default:   w_state_nxt = ST_WARMUP;
      endcase
   end

   // Both requesting: serve the one not granted last; otherwise the lone requester.
   always_comb begin
      w_grant_en = w_run && !w_rct_fail && r_smp_valid && (req != '0);
      w_pick     = (req == 2'b11) ? ~r_last : req[1];
      w_gnt      = '0;
      if (w_grant_en) w_gnt = w_pick ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_warm_cnt  <= '0;
         r_smp       <= '0;
         r_smp_valid <= 1'b0;
         r_last      <= 1'b1;
         r_gnt       <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_fault     <= 1'b0;
         r_src_en    <= 1'b0;
      end else begin
         r_src_en    <= (w_state_nxt != ST_FAULT);
         r_fault     <= (w_state_nxt == ST_FAULT);
         r_warm_cnt  <= (r_state == ST_WARMUP && w_state_nxt == ST_WARMUP)
                        ? r_warm_cnt + WARM_CNT_W'(1) : '0;
         // A fresh capture every RUN edge replaces smp, so no byte is delivered twice
         if (w_run) r_smp <= src_data;
         r_smp_valid <= w_run && !w_rct_fail;
         r_gnt       <= w_gnt;
         r_valid     <= w_grant_en;
         if (w_grant_en) begin
            r_data <= r_smp;
            r_last <= w_pick;
         end
      end
   end

   assign src_en    = r_src_en;
   assign gnt       = r_gnt;
   assign data_out  = r_data;
   assign valid_out = r_valid;
   assign fault     = r_fault;

endmodule

// File: tb/tb_trng_sched.sv
// Directed bench for trng_sched with WARMUP_CYCLES=8, RCT_LIMIT=4.
module tb_trng_sched;
   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic [7:0] src_data = 8'h00;
   logic       src_en;
   logic [1:0] req = 2'b11;
   logic [1:0] gnt;
   logic [7:0] data_out;
   logic       valid_out;
   logic       fault;
   logic       clr_fault = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   trng_sched #(.WARMUP_CYCLES(8), .RCT_LIMIT(4)) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .src_data  (src_data),
      .src_en    (src_en),
      .req       (req),
      .gnt       (gnt),
      .data_out  (data_out),
      .valid_out (valid_out),
      .fault     (fault),
      .clr_fault (clr_fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_gnt(input string tag, input logic [1:0] exp_gnt, input logic [7:0] exp_data);
      chk({tag, ".gnt"},   8'(gnt),       8'(exp_gnt));
      chk({tag, ".valid"}, 8'(valid_out), 8'(exp_gnt != 2'b00));
      chk({tag, ".data"},  data_out,      exp_data);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".src_en"}, 8'(src_en),    8'h00);
      chk({tag, ".gnt"},    8'(gnt),       8'h00);
      chk({tag, ".valid"},  8'(valid_out), 8'h00);
      chk({tag, ".data"},   data_out,      8'h00);
      chk({tag, ".fault"},  8'(fault),     8'h00);
   endtask

   initial begin
      // reset state
      step(); step();
      chk_reset("reset");

      // warmup: source enabled, no grants for 8 edges
      n_reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("warm.src_en", 8'(src_en), 8'h01);
         chk("warm.gnt",    8'(gnt),    8'h00);
      end

      // first RUN edge only captures
      src_data = 8'h01;
      step();
      chk("run1.gnt", 8'(gnt), 8'h00);

      // both requesting: alternate 01/10, successive captures
      for (int i = 0; i < 6; i++) begin
         src_data = 8'(2 + i);
         step();
         chk_gnt("rr", (i % 2 == 0) ? 2'b01 : 2'b10, 8'(1 + i));
      end

      // no request: data_out holds last granted byte
      req = 2'b00; src_data = 8'h08;
      step();
      chk_gnt("hold", 2'b00, 8'h06);

      // single requester 1 served every cycle; clr_fault in RUN ignored
      req = 2'b10; src_data = 8'h09;
      step();
      chk_gnt("solo0", 2'b10, 8'h08);
      src_data = 8'h0A; clr_fault = 1'b1;
      step();
      clr_fault = 1'b0;
      chk_gnt("solo1", 2'b10, 8'h09);
      chk("clr_run.fault", 8'(fault), 8'h00);
      src_data = 8'h0B;
      step();
      chk_gnt("solo2", 2'b10, 8'h0A);

      // reset mid-RUN
      n_reset = 1'b0;
      step();
      chk_reset("midreset");

      // constant source -> fault on 4th identical capture
      n_reset = 1'b1; req = 2'b11; src_data = 8'h32;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("warm2.gnt",    8'(gnt),    8'h00);
         chk("warm2.src_en", 8'(src_en), 8'h01);
      end
      step();
      chk("rct1.gnt", 8'(gnt), 8'h00);
      step();
      chk_gnt("rct2", 2'b01, 8'h32);
      step();
      chk_gnt("rct3", 2'b10, 8'h32);
      step();
      chk("rct4.fault",  8'(fault),  8'h01);
      chk("rct4.src_en", 8'(src_en), 8'h00);
      chk_gnt("rct4", 2'b00, 8'h32);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flt.fault",  8'(fault),  8'h01);
         chk("flt.src_en", 8'(src_en), 8'h00);
         chk("flt.gnt",    8'(gnt),    8'h00);
      end

      // clear fault -> warmup again, grants resume with requester 0
      src_data = 8'h40; clr_fault = 1'b1;
      step();
      clr_fault = 1'b0;
      chk("clr.fault",  8'(fault),  8'h00);
      chk("clr.src_en", 8'(src_en), 8'h01);
      chk("clr.gnt",    8'(gnt),    8'h00);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("warm3.gnt", 8'(gnt), 8'h00);
      end
      src_data = 8'h41;
      step();
      chk("run3.gnt", 8'(gnt), 8'h00);
      src_data = 8'h42;
      step();
      chk_gnt("resume0", 2'b01, 8'h41);
      src_data = 8'h43;
      step();
      chk_gnt("resume1", 2'b10, 8'h42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
